// File: rtl/fp_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_pkg
// Description : Shared types and constants for the FP adder alignment stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_align_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic isNan;
        logic isInf;
        logic isZero;
        logic isSub;
    } fp_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } align_state_t;

    localparam logic [7:0] EXP_MAX    = 8'hFF;
    localparam int         GUARD_BITS = 8;
    localparam int         SIG_W      = 32;

    // Exponent used for alignment: subnormals and zero behave as exponent 1.
    function automatic logic [7:0] effExp(input fp32_t v);
        return (v.exp == 8'd0) ? 8'd1 : v.exp;
    endfunction

    // Working significand: hidden bit, fraction, then empty guard bits.
    function automatic logic [SIG_W-1:0] sigOf(input fp32_t v);
        return {(v.exp != 8'd0), v.frac, {GUARD_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Combinational IEEE-754 binary32 operand classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import fp_align_pkg::*;
(
    input  fp32_t     operand,
    output fp_class_t cls
);

    logic w_expMax;
    logic w_expZero;
    logic w_fracZero;

    // Decode the exponent/fraction extremes into the four class flags.
    always_comb begin
        w_expMax    = (operand.exp == EXP_MAX);
        w_expZero   = (operand.exp == 8'd0);
        w_fracZero  = (operand.frac == 23'd0);
        cls.isNan   = w_expMax  && !w_fracZero;
        cls.isInf   = w_expMax  &&  w_fracZero;
        cls.isZero  = w_expZero &&  w_fracZero;
        cls.isSub   = w_expZero && !w_fracZero;
    end

endmodule
`default_nettype wire

// File: rtl/fp_align_serial.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_serial
// Description : Serial alignment front end of the binary32 adder. Orders the
//               operands by magnitude, right-shifts the smaller significand a
//               few bits per cycle with sticky collection, then adds or
//               subtracts and hands the result to the normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_align_serial
    import fp_align_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned SHIFT_CAP  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        a_nan,
    output logic        b_nan,
    output logic        a_inf,
    output logic        b_inf,
    output logic        a_zero,
    output logic        b_zero,
    output logic        a_sub,
    output logic        b_sub,
    output logic        sign_a,
    output logic        sign_b,
    output logic [31:0] aligned_result,
    output logic        carry_out,
    output logic        sticky,
    output logic [7:0]  exponent_out,
    output logic        aligned_sign
);

    localparam int unsigned c_REM_MAX = (SHIFT_CAP > SHIFT_STEP) ? SHIFT_CAP : SHIFT_STEP;
    localparam int unsigned c_REM_W   = $clog2(c_REM_MAX + 1);
    localparam logic [c_REM_W-1:0] c_CAP  = c_REM_W'(SHIFT_CAP);
    localparam logic [c_REM_W-1:0] c_STEP = c_REM_W'(SHIFT_STEP);

    align_state_t r_state;
    align_state_t w_nextState;

    fp32_t     w_opA;
    fp32_t     w_opB;
    fp32_t     w_opL;
    fp32_t     w_opS;
    fp_class_t w_clsA;
    fp_class_t w_clsB;

    logic                 w_aIsL;
    logic [7:0]           w_d;
    logic                 w_capHit;
    logic                 w_special;
    logic                 w_goShift;
    logic [c_REM_W-1:0]   w_remStart;
    logic [7:0]           w_expOut;
    logic [c_REM_W-1:0]   w_k;
    logic [2*SIG_W-1:0]   w_shifted;
    logic [SIG_W:0]       w_sum;
    logic [SIG_W-1:0]     w_diff;
    logic                 w_effAdd;

    logic [31:0]          r_outA;
    logic [31:0]          r_outB;
    fp_class_t            r_clsA;
    fp_class_t            r_clsB;
    logic                 r_signA;
    logic                 r_signB;
    logic                 r_lSign;
    logic [SIG_W-1:0]     r_sigL;
    logic [SIG_W-1:0]     r_sigS;
    logic [c_REM_W-1:0]   r_remain;
    logic                 r_sticky;
    logic [7:0]           r_expOut;
    logic [SIG_W-1:0]     r_result;
    logic                 r_carry;
    logic                 r_alignedSign;

    // Subtraction is folded in by flipping B's sign at the input.
    assign w_opA = a;
    assign w_opB = {b[31] ^ op_sub, b[30:0]};

    fp_classify u_classA (
        .operand (w_opA),
        .cls     (w_clsA)
    );

    fp_classify u_classB (
        .operand (w_opB),
        .cls     (w_clsB)
    );

    // Magnitude ordering, shift distance and routing decision for a new pair.
    always_comb begin
        w_aIsL     = {effExp(w_opA), w_opA.frac} >= {effExp(w_opB), w_opB.frac};
        w_opL      = w_aIsL ? w_opA : w_opB;
        w_opS      = w_aIsL ? w_opB : w_opA;
        w_d        = effExp(w_opL) - effExp(w_opS);
        w_capHit   = 32'(w_d) >= SHIFT_CAP;
        w_remStart = w_capHit ? c_CAP : c_REM_W'(w_d);
        // A subnormal larger operand reports exponent 1; zero keeps its field.
        w_expOut   = ((w_opL.exp == 8'd0) && (w_opL.frac != 23'd0)) ? 8'd1 : w_opL.exp;
        w_special  = w_clsA.isNan || w_clsA.isInf || w_clsA.isZero ||
                     w_clsB.isNan || w_clsB.isInf || w_clsB.isZero;
        w_goShift  = (w_d != 8'd0) && !w_special;
    end

    // One shift step: the low half of the wide shift holds the exiting bits.
    always_comb begin
        w_k       = (r_remain > c_STEP) ? c_STEP : r_remain;
        w_shifted = {r_sigS, {SIG_W{1'b0}}} >> w_k;
    end

    // Add/subtract of the aligned significands; L >= S so no negative result.
    always_comb begin
        w_effAdd = (r_signA == r_signB);
        w_sum    = {1'b0, r_sigL} + {1'b0, r_sigS};
        w_diff   = r_sigL - r_sigS;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = w_goShift ? SHIFT : ADD;
            SHIFT:   if (r_remain == w_k) w_nextState = ADD;
            ADD:     w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath: capture in IDLE, shift in SHIFT, combine in ADD, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outA        <= '0;
            r_outB        <= '0;
            r_clsA        <= '0;
            r_clsB        <= '0;
            r_signA       <= 1'b0;
            r_signB       <= 1'b0;
            r_lSign       <= 1'b0;
            r_sigL        <= '0;
            r_sigS        <= '0;
            r_remain      <= '0;
            r_sticky      <= 1'b0;
            r_expOut      <= '0;
            r_result      <= '0;
            r_carry       <= 1'b0;
            r_alignedSign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_outA   <= a;
                        r_outB   <= w_opB;
                        r_clsA   <= w_clsA;
                        r_clsB   <= w_clsB;
                        r_signA  <= w_opA.sign;
                        r_signB  <= w_opB.sign;
                        r_lSign  <= w_opL.sign;
                        r_sigL   <= sigOf(w_opL);
                        r_sigS   <= sigOf(w_opS);
                        r_remain <= w_remStart;
                        r_sticky <= 1'b0;
                        r_expOut <= w_expOut;
                    end
                end
                SHIFT: begin
                    r_sigS   <= w_shifted[2*SIG_W-1:SIG_W];
                    r_sticky <= r_sticky | (|w_shifted[SIG_W-1:0]);
                    r_remain <= r_remain - w_k;
                end
                ADD: begin
                    if (w_effAdd) begin
                        r_carry       <= w_sum[SIG_W];
                        r_result      <= w_sum[SIG_W-1:0];
                        r_alignedSign <= r_lSign;
                    end else begin
                        r_carry       <= 1'b0;
                        r_result      <= w_diff;
                        // Exact cancellation always yields +0.
                        r_alignedSign <= (w_diff == '0) ? 1'b0 : r_lSign;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_a          = r_outA;
    assign out_b          = r_outB;
    assign a_nan          = r_clsA.isNan;
    assign b_nan          = r_clsB.isNan;
    assign a_inf          = r_clsA.isInf;
    assign b_inf          = r_clsB.isInf;
    assign a_zero         = r_clsA.isZero;
    assign b_zero         = r_clsB.isZero;
    assign a_sub          = r_clsA.isSub;
    assign b_sub          = r_clsB.isSub;
    assign sign_a         = r_signA;
    assign sign_b         = r_signB;
    assign aligned_result = r_result;
    assign carry_out      = r_carry;
    assign sticky         = r_sticky;
    assign exponent_out   = r_expOut;
    assign aligned_sign   = r_alignedSign;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_align_serial
// Description : Self-checking bench for fp_align_serial: vector table with a
//               scoreboard queue, plus back-pressure and abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_align_serial;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        carry;
        logic        stk;
        logic [7:0]  expo;
        logic        sign;
        logic [7:0]  flags;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub;
    logic        sign_a, sign_b;
    logic [31:0] aligned_result;
    logic        carry_out;
    logic        sticky;
    logic [7:0]  exponent_out;
    logic        aligned_sign;
    logic [7:0]  flagsV;

    int   total = 0;
    int   bad   = 0;
    vec_t sbq[$];
    vec_t vecs[12];

    fp_align_serial #(
        .SHIFT_STEP (4),
        .SHIFT_CAP  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .op_sub         (op_sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_b          (out_b),
        .a_nan          (a_nan),
        .b_nan          (b_nan),
        .a_inf          (a_inf),
        .b_inf          (b_inf),
        .a_zero         (a_zero),
        .b_zero         (b_zero),
        .a_sub          (a_sub),
        .b_sub          (b_sub),
        .sign_a         (sign_a),
        .sign_b         (sign_b),
        .aligned_result (aligned_result),
        .carry_out      (carry_out),
        .sticky         (sticky),
        .exponent_out   (exponent_out),
        .aligned_sign   (aligned_sign)
    );

    assign flagsV = {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a_, input logic [31:0] b_, input logic s_,
                                input logic [31:0] r_, input logic c_, input logic st_,
                                input logic [7:0] e_, input logic sg_, input logic [7:0] f_,
                                input int l_);
        vec_t v;
        v.a = a_; v.b = b_; v.sub = s_; v.res = r_; v.carry = c_; v.stk = st_;
        v.expo = e_; v.sign = sg_; v.flags = f_; v.lat = l_;
        return v;
    endfunction

    // Present one operand pair, log its expectation, and let it be accepted.
    task automatic drive(input vec_t v);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        op_sub   = v.sub;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic waitResult(output int k, output bit ok);
        k  = 0;
        ok = 1'b0;
        while (k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic compareResult(input int k);
        vec_t e;
        e = sbq.pop_front();
        check("latency",        64'(k + 1),          64'(e.lat));
        check("aligned_result", 64'(aligned_result), 64'(e.res));
        check("carry_out",      64'(carry_out),      64'(e.carry));
        check("sticky",         64'(sticky),         64'(e.stk));
        check("exponent_out",   64'(exponent_out),   64'(e.expo));
        check("aligned_sign",   64'(aligned_sign),   64'(e.sign));
        check("flags",          64'(flagsV),         64'(e.flags));
        check("sign_a",         64'(sign_a),         64'(e.a[31]));
        check("sign_b",         64'(sign_b),         64'(e.b[31] ^ e.sub));
        check("out_a",          64'(out_a),          64'(e.a));
        check("out_b",          64'(out_b),          64'({e.b[31] ^ e.sub, e.b[30:0]}));
        check("in_ready_busy",  64'(in_ready),       64'(0));
    endtask

    task automatic release1();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after", 64'(in_ready), 64'(1));
        check("valid_after",    64'(out_valid), 64'(0));
    endtask

    task automatic runVec(input vec_t v);
        int k;
        bit ok;
        drive(v);
        waitResult(k, ok);
        check("result_seen", 64'(ok), 64'(1));
        if (ok) compareResult(k);
        else void'(sbq.pop_front());
        release1();
    endtask

    initial begin
        int  k;
        bit  ok;
        bit  seen;
        vec_t nv;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b0;

        vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'h7F, 1'b0, 8'h00, 2);
        vecs[1]  = mk(32'h3F800000, 32'h30800000, 1'b0, 32'h80000002, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 10);
        vecs[2]  = mk(32'h3F800000, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h01, 10);
        vecs[3]  = mk(32'h3F800000, 32'h40000000, 1'b1, 32'h40000000, 1'b0, 1'b0, 8'h80, 1'b1, 8'h00, 3);
        vecs[4]  = mk(32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 2);
        vecs[5]  = mk(32'h40000000, 32'h3F800000, 1'b0, 32'hC0000000, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 3);
        vecs[6]  = mk(32'h3F800000, 32'h33800001, 1'b0, 32'h80000080, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 8);
        vecs[7]  = mk(32'h3F800000, 32'h2F800000, 1'b0, 32'h80000000, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 10);
        vecs[8]  = mk(32'h3F800000, 32'h30000000, 1'b0, 32'h80000001, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 10);
        vecs[9]  = mk(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 2);
        vecs[10] = mk(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 2);
        vecs[11] = mk(32'h3F800000, 32'hB3800001, 1'b0, 32'h7FFFFF80, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 8);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),       64'(1));
        check("rst_out_valid", 64'(out_valid),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready",  64'(in_ready),       64'(1));
        check("idle_out_valid", 64'(out_valid),      64'(0));
        check("idle_result",    64'(aligned_result), 64'(0));
        check("idle_exponent",  64'(exponent_out),   64'(0));
        check("idle_out_a",     64'(out_a),          64'(0));
        check("idle_flags",     64'(flagsV),         64'(0));
        check("idle_carry",     64'(carry_out),      64'(0));
        check("idle_sticky",    64'(sticky),         64'(0));

        for (int i = 0; i < 12; i++) runVec(vecs[i]);

        // NaN operand with downstream back-pressure; a new pair is offered
        // meanwhile and must not disturb the held result.
        nv = mk(32'h7FC00000, 32'h3F800000, 1'b0, 32'h40000000, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h80, 2);
        drive(nv);
        waitResult(k, ok);
        check("nan_seen", 64'(ok), 64'(1));
        if (ok) compareResult(k);
        else void'(sbq.pop_front());
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F800000;
        b        = 32'h30800000;
        op_sub   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid",    64'(out_valid),      64'(1));
            check("hold_in_ready", 64'(in_ready),       64'(0));
            check("hold_a_nan",    64'(a_nan),          64'(1));
            check("hold_out_a",    64'(out_a),          64'(32'h7FC00000));
            check("hold_result",   64'(aligned_result), 64'(32'h40000000));
            check("hold_exponent", 64'(exponent_out),   64'(8'hFF));
        end
        @(negedge clk);
        in_valid = 1'b0;
        release1();

        // Abort a shifting operation with reset in cycle 4.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F800000;
        b        = 32'h30800000;
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_busy", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("abort_not_done", 64'(out_valid), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid),      64'(0));
        check("abort_in_ready",  64'(in_ready),       64'(1));
        check("abort_result",    64'(aligned_result), 64'(0));
        check("abort_out_a",     64'(out_a),          64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'(0));

        // Normal operation resumes after the abort.
        runVec(vecs[1]);
        check("queue_empty", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_align_serial.md
Name: fp_align_serial

Overview:
- Front-end alignment stage of the single-precision FP adder. It is the producer that feeds the normalize/round stage.
- Unpacks and classifies two IEEE-754 binary32 operands and orders them by magnitude.
- Right-shifts the smaller significand iteratively, SHIFT_STEP bits per cycle, collecting sticky. Then adds or subtracts.
- Presents the aligned sum plus operand class flags on a valid/ready handshake in exactly the field layout the normalizer consumes.

Parameters:
- SHIFT_STEP, 4: maximum right-shift bits applied per SHIFT cycle (1..32).
- SHIFT_CAP, 32: shift distances at or above this saturate. Significand becomes 0 and all nonzero bits go to sticky.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block idle, can accept.
- a  in  32  operand A.
- b  in  32  operand B.
- op_sub  in  1  1 = A-B (B sign inverted at capture).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_a  out  32  captured A.
- out_b  out  32  captured B, effective sign applied.
- a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_sub, b_sub  out  1 each  class flags.
- sign_a, sign_b  out  1 each  operand signs, sign_b effective.
- aligned_result  out  32  significand sum: hidden bit at [31], fraction [30:8], guard bits [7:0].
- carry_out  out  1  bit 32 of the addition.
- sticky  out  1  OR of all bits shifted below bit 0.
- exponent_out  out  8  biased exponent of the larger-magnitude operand.
- aligned_sign  out  1  result sign.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. in_ready=1, out_valid=0.
  - All datapath outputs are 0. No pending work survives.
- Classification:
  - NaN: exp=FF, frac≠0. Inf: exp=FF, frac=0.
  - Zero: exp=0, frac=0. Sub: exp=0, frac≠0.
- Significand: {hidden, frac, 8'b0}. Hidden = (exp≠0). Effective exponent = max(exp,1).
- Ordering:
  - L = operand with larger {eff_exp, frac}; S = the other. On equality L = A.
  - d = eff_exp(L) - eff_exp(S).
  - exponent_out = exp field of L, or 1 when both are subnormal with eff_exp 1 (normalizer applies its own subnormal rule).
- State IDLE:
  - in_ready=1. On in_valid, capture operands, flags and d.
  - Go to SHIFT if d≠0 and no NaN/Inf/Zero flag is set; otherwise go to ADD.
- State SHIFT:
  - Each cycle, shift S right by k = min(remaining, SHIFT_STEP) and OR the k exiting bits into sticky.
  - When d ≥ SHIFT_CAP, remaining starts at SHIFT_CAP, which clears the significand.
  - Leave for ADD when remaining reaches 0. Cycle count = ceil(min(d,SHIFT_CAP)/SHIFT_STEP).
- State ADD (1 cycle):
  - Effective add (sign_a==sign_b): {carry_out, aligned_result} = L + S, 33-bit.
  - Otherwise subtract L - S. carry_out=0; never negative because L ≥ S.
  - aligned_sign = sign of L. Exact cancellation forces aligned_sign=0 and aligned_result=0.
  - For special cases, data fields are don't-care but deterministic; flags are authoritative.
- State DONE:
  - out_valid=1. All outputs hold stable while out_ready=0.
  - When out_ready=1, go to IDLE on the next cycle.
  - in_ready=0 in every state except IDLE. No back-to-back overlap.
- Latency: accept edge = cycle 0, out_valid in cycle 2 + shift cycles.
- in_valid while busy is ignored; the source must hold it.
- rst_n asserted mid-SHIFT/ADD/DONE aborts the operation. out_valid drops immediately (async).

Decomposition:
- Package fp_align_pkg holds:
  - fp32_t packed struct {sign, exp[7:0], frac[22:0]}.
  - fp_class_t flag struct.
  - align_state_t enum {IDLE, SHIFT, ADD, DONE}.
  - Constants EXP_MAX=8'hFF, GUARD_BITS=8, SIG_W=32.
- One sub-module, fp_classify: combinational fp32_t to fp_class_t, instantiated twice.

Test Plan:
- a=3F800000, b=3F800000, add → d=0, out_valid cycle 2, carry_out=1, aligned_result=00000000, exponent_out=7F, sticky=0, aligned_sign=0.
- a=3F800000, b=30800000, add → d=30, 8 SHIFT cycles, out_valid cycle 10, aligned_result=80000002, carry_out=0, sticky=0.
- a=3F800000, b=00000001 (subnormal) → d=126 capped at 32, 8 SHIFT cycles, aligned_result=80000000, sticky=1, b_sub=1, exponent_out=7F.
- a=3F800000, b=40000000, op_sub=1 → L=B, d=1, out_valid cycle 3, aligned_result=40000000, aligned_sign=1, exponent_out=80, sign_b=1.
- a=40490FDB, b=40490FDB, op_sub=1 → aligned_result=0, carry_out=0, aligned_sign=0, sticky=0.
- a=7FC00000, b=3F800000 → a_nan=1, out_valid cycle 2. Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0. Next op a=3F800000, b=30800000: pull rst_n low in cycle 4 → out_valid=0 and in_ready=1 immediately; no result ever appears.
